// File: rtl/elixirchip_es1_spu_arb_pkg.sv
// Shared types and helpers for the SPU single-op arbiter.
package elixirchip_es1_spu_arb_pkg;

    // Requester index width sized for the largest supported requester count (16).
    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Token travelling alongside the op unit's pipeline.
    typedef struct packed {
        logic             valid;
        logic             clr;
        logic [IDX_W-1:0] id;
    } tag_t;

    // Next index in round-robin order, wrapping at num.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W:0]   num);
        logic [IDX_W:0] inc;
        inc = {1'b0, idx} + {{IDX_W{1'b0}}, 1'b1};
        if (inc >= num) begin
            return '0;
        end else begin
            return inc[IDX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/elixirchip_es1_rr_arbiter.sv
// Round-robin grant: searches last+1 .. last and grants the first active request.
module elixirchip_es1_rr_arbiter
    import elixirchip_es1_spu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   last_d;
    logic [IDX_W-1:0]   cand_s;
    logic               found_s;

    // Walk candidates in round-robin order starting after the last grant.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = last_q;
        cand_s      = last_q;
        found_s     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = rr_next(cand_s, NUM_REQ_W);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found_s && req_i[i] && (cand_s == IDX_W'(i))) begin
                    grant_o[i]  = 1'b1;
                    grant_idx_o = cand_s;
                    found_s     = 1'b1;
                end else begin
                    grant_o[i] = grant_o[i];
                end
            end
        end
    end

    // Pointer only moves when a grant is actually taken.
    always_comb begin
        if (advance_i) begin
            last_d = grant_idx_o;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; reset value makes requester 0 win first.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= LAST_RST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/elixirchip_es1_spu_op_arbiter.sv
// Shares one pipelined SPU op unit among NUM_REQ requesters, routes results
// back through a tag pipeline and sequences op-unit clears.
module elixirchip_es1_spu_op_arbiter
    import elixirchip_es1_spu_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int LATENCY     = 1,
    parameter int DATA_BITS   = 8,
    parameter int RESULT_BITS = 1
) (
    input  logic                              reset,
    input  logic                              clk,
    input  logic                              cke,
    input  logic [NUM_REQ-1:0][DATA_BITS-1:0] s_data,
    input  logic [NUM_REQ-1:0]                s_valid,
    output logic [NUM_REQ-1:0]                s_ready,
    output logic [RESULT_BITS-1:0]            m_result,
    output logic [NUM_REQ-1:0]                m_valid,
    input  logic                              c_clear,
    output logic                              c_done,
    output logic                              busy,
    output logic [DATA_BITS-1:0]              op_data,
    output logic                              op_valid,
    output logic                              op_clear,
    input  logic [RESULT_BITS-1:0]            op_result
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    state_e             state_q;
    state_e             state_d;
    tag_t               pipe_q [0:LATENCY-1];
    tag_t               tag_in_s;
    tag_t               exit_s;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               grant_en_s;
    logic               clr_accept_s;
    logic               exit_clr_s;
    logic               exit_fire_s;
    logic [NUM_REQ-1:0] req_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;

    // Grants only in RUN with cke; a clear request wins over every requester.
    assign grant_en_s   = cke & ~reset & (state_q == ST_RUN) & ~c_clear;
    assign clr_accept_s = cke & ~reset & (state_q == ST_RUN) & c_clear;
    assign req_s        = grant_en_s ? s_valid : '0;
    assign s_ready      = grant_s;
    assign op_valid     = |grant_s;
    assign op_clear     = cke & (state_q == ST_CLEAR);

    assign exit_s       = pipe_q[LATENCY-1];
    assign exit_clr_s   = exit_s.valid & exit_s.clr;
    assign exit_fire_s  = exit_s.valid & cke;
    assign c_done       = exit_clr_s;
    assign busy         = (cnt_q != '0) | (state_q != ST_RUN);

    elixirchip_es1_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_i       (req_s),
        .advance_i   (|grant_s),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        op_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                op_data = op_data | s_data[i];
            end else begin
                op_data = op_data;
            end
        end
    end

    // Token entering the pipeline. The clear token is launched on the edge
    // that enters CLEAR so that it leaves LATENCY-1 cycles after op_clear.
    always_comb begin
        tag_in_s = '0;
        if (|grant_s) begin
            tag_in_s = '{valid: 1'b1, clr: 1'b0, id: grant_idx_s};
        end else if (clr_accept_s) begin
            tag_in_s = '{valid: 1'b1, clr: 1'b1, id: '0};
        end else begin
            tag_in_s = '0;
        end
    end

    // Result routing from the exit stage; held while cke is low.
    always_comb begin
        if (exit_s.valid && !exit_s.clr) begin
            m_valid  = NUM_REQ'(1'b1) << exit_s.id;
            m_result = op_result;
        end else begin
            m_valid  = '0;
            m_result = '0;
        end
    end

    // Next-state logic: RUN -> CLEAR -> WAIT -> RUN when the clear token exits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (clr_accept_s) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CLEAR, ST_WAIT: begin
                if (cke && exit_clr_s) begin
                    state_d = ST_RUN;
                end else if (cke) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // In-flight token count: +1 on entry, -1 on exit.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(tag_in_s.valid) - CNT_W'(exit_fire_s);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else if (cke) begin
            state_q <= state_d;
        end
    end

    // In-flight counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cke) begin
            cnt_q <= cnt_d;
        end
    end

    // Tag shift register matched to the op unit's latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (cke) begin
            pipe_q[0] <= tag_in_s;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_arbiter.sv
// Directed bench for the SPU op arbiter with an event-level reference model.
module tb_elixirchip_es1_spu_op_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 3;
    localparam int DB  = 8;
    localparam int RB  = 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   cke = 1'b1;
    logic                   c_clear = 1'b0;
    logic [NR-1:0][DB-1:0]  s_data = '0;
    logic [NR-1:0]          s_valid = '0;
    logic [NR-1:0]          s_ready;
    logic [RB-1:0]          m_result;
    logic [NR-1:0]          m_valid;
    logic                   c_done;
    logic                   busy;
    logic [DB-1:0]          op_data;
    logic                   op_valid;
    logic                   op_clear;
    logic [RB-1:0]          op_result;

    elixirchip_es1_spu_op_arbiter #(
        .NUM_REQ(NR), .LATENCY(LAT), .DATA_BITS(DB), .RESULT_BITS(RB)
    ) dut (
        .reset(reset), .clk(clk), .cke(cke),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_result(m_result), .m_valid(m_valid),
        .c_clear(c_clear), .c_done(c_done), .busy(busy),
        .op_data(op_data), .op_valid(op_valid), .op_clear(op_clear),
        .op_result(op_result)
    );

    always #5 clk = ~clk;

    // Stand-in op unit: OR-reduce with LAT cke-gated stages; clear data is 0.
    logic [LAT-1:0] op_pipe = '0;
    always @(posedge clk) begin
        if (cke) op_pipe <= {op_pipe[LAT-2:0], op_valid & (|op_data)};
    end
    assign op_result = op_pipe[LAT-1];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: events scheduled by cke-cycle index.
    logic [NR-1:0] exp_mv   [0:1023];
    logic          exp_res  [0:1023];
    logic          exp_done [0:1023];
    logic          issued   [0:1023];
    int m_cc, m_last, m_run_from, m_clr_at;

    // Observation logs (actual DUT behaviour, checked against literals).
    int g_log[$];
    int g_cc[$];
    int r_log[$];
    int r_cc[$];
    int done_n, done_cc, oclr_cc;

    task automatic clear_logs();
        g_log.delete(); g_cc.delete(); r_log.delete(); r_cc.delete();
        done_n = 0; done_cc = -1; oclr_cc = -1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 1024; i++) begin
            exp_mv[i] = '0; exp_res[i] = 1'b0; exp_done[i] = 1'b0; issued[i] = 1'b0;
        end
        m_cc = 0; m_last = NR - 1; m_run_from = 0; m_clr_at = -10;
    endtask

    // Compare process: every negedge, derive expected outputs and check them.
    initial begin
        logic [NR-1:0] e_ready;
        logic [DB-1:0] e_opd;
        logic          e_busy;
        logic          run;
        int            g;
        int            idx;
        m_reset();
        forever begin
            @(negedge clk);
            if (reset) begin
                m_reset();
                chk("rst_s_ready", s_ready, 0);
                chk("rst_m_valid", m_valid, 0);
                chk("rst_c_done", c_done, 0);
                chk("rst_op_valid", op_valid, 0);
                chk("rst_op_clear", op_clear, 0);
                chk("rst_busy", busy, 0);
                chk("rst_op_data", op_data, 0);
                chk("rst_m_result", m_result, 0);
            end else begin
                e_ready = '0; g = -1;
                run = (m_cc >= m_run_from);
                if (cke && run && !c_clear) begin
                    for (int k = 1; k <= NR; k++) begin
                        idx = (m_last + k) % NR;
                        if (g < 0 && s_valid[idx]) begin
                            e_ready[idx] = 1'b1; g = idx;
                        end
                    end
                end
                e_opd = (g >= 0) ? s_data[g] : '0;
                e_busy = !run;
                for (int d = 1; d <= LAT; d++)
                    if (m_cc - d >= 0 && issued[m_cc - d]) e_busy = 1'b1;
                chk("s_ready", s_ready, e_ready);
                chk("op_valid", op_valid, (g >= 0));
                chk("op_data", op_data, e_opd);
                chk("op_clear", op_clear, cke && (m_cc == m_clr_at + 1));
                chk("m_valid", m_valid, exp_mv[m_cc]);
                chk("m_result", m_result, exp_mv[m_cc] != 0 ? exp_res[m_cc] : 1'b0);
                chk("c_done", c_done, exp_done[m_cc]);
                chk("busy", busy, e_busy);
                if (cke) begin
                    if (s_ready != 0) begin g_log.push_back(oh2i(s_ready)); g_cc.push_back(m_cc); end
                    if (m_valid != 0) begin r_log.push_back(oh2i(m_valid) * 2 + int'(m_result)); r_cc.push_back(m_cc); end
                    if (op_clear) oclr_cc = m_cc;
                    if (c_done) begin done_n++; done_cc = m_cc; end
                    if (g >= 0) begin
                        exp_mv[m_cc + LAT] = e_ready;
                        exp_res[m_cc + LAT] = |s_data[g];
                        issued[m_cc] = 1'b1;
                        m_last = g;
                    end else if (run && c_clear) begin
                        exp_done[m_cc + LAT] = 1'b1;
                        issued[m_cc] = 1'b1;
                        m_clr_at = m_cc;
                        m_run_from = m_cc + LAT + 1;
                    end
                    m_cc++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        logic       cke_tab [0:9];
        logic [3:0] val_tab [0:9];
        clear_logs();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 1: all requesters valid -> 0,1,2,3,0
        clear_logs();
        s_data[0] = 8'h01; s_data[1] = 8'h00; s_data[2] = 8'h80; s_data[3] = 8'h00;
        s_valid = 4'hF;
        repeat (5) tick();
        s_valid = 4'h0;
        repeat (6) tick();
        chk("t1_ngrant", g_log.size(), 5);
        if (g_log.size() == 5) begin
            chk("t1_g0", g_log[0], 0); chk("t1_g1", g_log[1], 1);
            chk("t1_g2", g_log[2], 2); chk("t1_g3", g_log[3], 3); chk("t1_g4", g_log[4], 0);
        end
        chk("t1_nres", r_log.size(), 5);
        if (r_log.size() == 5) begin
            chk("t1_r0", r_log[0], 1); chk("t1_r1", r_log[1], 2);
            chk("t1_r2", r_log[2], 5); chk("t1_r3", r_log[3], 6); chk("t1_r4", r_log[4], 1);
            chk("t1_lat", r_cc[0] - g_cc[0], 3);
        end

        // 2: only requester 2, data 0x00 then 0x40
        clear_logs();
        s_valid = 4'b0100; s_data[2] = 8'h00;
        tick();
        s_data[2] = 8'h40;
        tick();
        s_valid = 4'h0;
        repeat (5) tick();
        chk("t2_ngrant", g_log.size(), 2);
        chk("t2_nres", r_log.size(), 2);
        if (r_log.size() == 2) begin
            chk("t2_r0", r_log[0], 4); chk("t2_r1", r_log[1], 5);
        end

        // 3: cke toggling during traffic
        clear_logs();
        s_data[0] = 8'h10; s_data[1] = 8'h00;
        cke_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        val_tab = '{4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000,
                    4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 10; i++) begin
            cke = cke_tab[i]; s_valid = val_tab[i];
            tick();
        end
        cke = 1'b1; s_valid = 4'h0;
        repeat (4) tick();
        chk("t3_ngrant", g_log.size(), 2);
        chk("t3_nres", r_log.size(), 2);
        if (g_log.size() == 2 && r_log.size() == 2) begin
            chk("t3_g0", g_log[0], 0); chk("t3_g1", g_log[1], 1);
            chk("t3_r0", r_log[0], 1); chk("t3_r1", r_log[1], 2);
            chk("t3_lat", r_cc[0] - g_cc[0], 3);
        end

        // 4: clear together with s_valid[1]
        clear_logs();
        s_data[1] = 8'h02; s_valid = 4'b0010; c_clear = 1'b1;
        tick();
        c_clear = 1'b0;
        repeat (4) tick();
        s_valid = 4'h0;
        repeat (5) tick();
        chk("t4_ngrant", g_log.size(), 1);
        chk("t4_ndone", done_n, 1);
        chk("t4_done_lat", done_cc - oclr_cc, 2);
        if (g_log.size() == 1) begin
            chk("t4_g0", g_log[0], 1);
            chk("t4_resume", g_cc[0] - oclr_cc, 3);
        end
        chk("t4_nres", r_log.size(), 1);
        if (r_log.size() == 1) chk("t4_r0", r_log[0], 3);

        // 5: clear re-asserted during WAIT is ignored
        clear_logs();
        c_clear = 1'b1; tick();
        c_clear = 1'b0; tick();
        c_clear = 1'b1; tick(); tick();
        c_clear = 1'b0;
        repeat (6) tick();
        chk("t5_ndone", done_n, 1);
        chk("t5_nres", r_log.size(), 0);

        // 6: async reset with two tokens in flight
        s_data[2] = 8'h01; s_data[1] = 8'h01; s_data[0] = 8'h10;
        s_valid = 4'b0100; tick();
        s_valid = 4'b0010; tick();
        s_valid = 4'h0; tick();
        s_valid = 4'hF; reset = 1'b1; clear_logs();
        #1;
        chk("t6_s_ready", s_ready, 0);
        chk("t6_m_valid", m_valid, 0);
        chk("t6_c_done", c_done, 0);
        chk("t6_op_valid", op_valid, 0);
        chk("t6_busy", busy, 0);
        tick(); tick();
        reset = 1'b0; s_valid = 4'b0101;
        tick();
        s_valid = 4'h0;
        repeat (6) tick();
        chk("t6_ngrant", g_log.size(), 1);
        if (g_log.size() == 1) chk("t6_g0", g_log[0], 0);
        chk("t6_nres", r_log.size(), 1);
        if (r_log.size() == 1) chk("t6_r0", r_log[0], 1);
        chk("t6_ndone", done_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
